// File: rtl/multi_edge_sync_if.sv
// Handshake/bus bundle for multi_edge_sync: async level inputs, per-channel
// mode/ack controls, and the synchronised level, event and counter outputs.
interface multi_edge_sync_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       async_in;
  logic [2*CH-1:0]     edge_mode;
  logic [CH-1:0]       evt_ack;
  logic                cnt_clr;
  logic [CH-1:0]       lvl_out;
  logic [CH-1:0]       evt_pulse;
  logic [CH-1:0]       evt_pend;
  logic [CH-1:0]       evt_ovf;
  logic [CH*CNT_W-1:0] evt_cnt;

  modport master (
    output async_in, edge_mode, evt_ack, cnt_clr,
    input  lvl_out, evt_pulse, evt_pend, evt_ovf, evt_cnt
  );

  modport slave (
    input  async_in, edge_mode, evt_ack, cnt_clr,
    output lvl_out, evt_pulse, evt_pend, evt_ovf, evt_cnt
  );
endinterface

// File: rtl/multi_edge_sync.sv
// Multi-channel async edge detector: synchroniser, optional glitch filter
// (EDGE_SYNC_FILTER_EN), edge qualification, pend/ovf flags, saturating counters.
module multi_edge_sync #(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int FILT_LEN = 3,
  parameter int CNT_W    = 8
) (
  input logic              clk_b,
  input logic              rst_n_b,
  multi_edge_sync_if.slave bus
);

  logic [CH-1:0]      sync_q [SYNC_STG];
  logic [CH-1:0]      sync_d [SYNC_STG];
  logic [CH-1:0]      lvl;
  logic [CH-1:0]      prev_q, prev_d;
  logic [CH-1:0]      evt;
  logic [CH-1:0]      pulse_q, pulse_d;
  logic [CH-1:0]      pend_q, pend_d;
  logic [CH-1:0]      ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q [CH];
  logic [CNT_W-1:0]   cnt_d [CH];
  logic [CH*CNT_W-1:0] cnt_flat;

  always_comb begin
    sync_d[0] = bus.async_in;
    for (int unsigned s = 1; s < SYNC_STG; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      for (int unsigned s = 0; s < SYNC_STG; s++) sync_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < SYNC_STG; s++) sync_q[s] <= sync_d[s];
    end
  end

`ifdef EDGE_SYNC_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [CH-1:0] filt_q, filt_d;
  logic [3:0]    fcnt_q [CH];
  logic [3:0]    fcnt_d [CH];

  // Counter runs only while synced and filtered levels disagree; reaching
  // FILT_LEN consecutive disagreeing cycles adopts the synced level.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < CH; i++) begin
      fcnt_d[i] = '0;
      if (sync_q[SYNC_STG-1][i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = sync_q[SYNC_STG-1][i];
        else                        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < CH; i++) fcnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < CH; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STG-1];
`endif

  always_comb begin
    prev_d = lvl;
    evt    = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      case (bus.edge_mode[2*i +: 2])
        2'b00:   evt[i] = lvl[i] & ~prev_q[i];
        2'b01:   evt[i] = ~lvl[i] & prev_q[i];
        2'b10:   evt[i] = lvl[i] ^ prev_q[i];
        default: evt[i] = 1'b0;
      endcase
    end
  end

  // An event always leaves pend set; ovf records a loss only when the
  // event is not covered by a same-cycle ack.
  always_comb begin
    pulse_d = evt;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (evt[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i]) ovf_d[i] = ~bus.evt_ack[i];
      end else if (bus.evt_ack[i] && pend_q[i]) begin
        pend_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end
      if (bus.cnt_clr) begin
        cnt_d[i] = evt[i] ? CNT_W'(1) : '0;
      end else if (evt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      prev_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_flat[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end

  assign bus.lvl_out   = lvl;
  assign bus.evt_pulse = pulse_q;
  assign bus.evt_pend  = pend_q;
  assign bus.evt_ovf   = ovf_q;
  assign bus.evt_cnt   = cnt_flat;

endmodule

// File: tb/tb_multi_edge_sync.sv
// Bench for multi_edge_sync: pulse-timing scoreboard, flag/counter vector table,
// and directed sequences for reset, saturation, mode switching and glitches.
module tb_multi_edge_sync;
  localparam int SS = 2;
  localparam int FL = 3;
`ifdef EDGE_SYNC_FILTER_EN
  localparam int LAT = SS + FL;
`else
  localparam int LAT = SS;
`endif

  logic clk_b   = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk_b = ~clk_b;

  multi_edge_sync_if #(.CH(4), .CNT_W(8)) bus ();
  multi_edge_sync_if #(.CH(2), .CNT_W(2)) bus_s ();

  multi_edge_sync #(.CH(4), .SYNC_STG(SS), .FILT_LEN(FL), .CNT_W(8)) dut (
    .clk_b(clk_b), .rst_n_b(rst_n_b), .bus(bus));
  multi_edge_sync #(.CH(2), .SYNC_STG(SS), .FILT_LEN(FL), .CNT_W(2)) dut_s (
    .clk_b(clk_b), .rst_n_b(rst_n_b), .bus(bus_s));

  typedef struct { int unit; int ch; int cyc; } exp_t;
  typedef struct { bit tog; bit ack; bit clr; bit pend; bit ovf; int cnt; } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk_b) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_m(int ch);
    return int'(bus.evt_cnt[8*ch +: 8]);
  endfunction

  function automatic int cnt_s(int ch);
    return int'(bus_s.evt_cnt[2*ch +: 2]);
  endfunction

  // Pulse due at the negedge after edge (next edge + LAT).
  task automatic expect_evt(int unit, int ch);
    sb.push_back('{unit, ch, cyc + 1 + LAT});
  endtask

  task automatic tog(int ch, bit exp_evt);
    bus.async_in[ch] = ~bus.async_in[ch];
    if (exp_evt) expect_evt(0, ch);
  endtask

  task automatic tog_s(int ch, bit exp_evt);
    bus_s.async_in[ch] = ~bus_s.async_in[ch];
    if (exp_evt) expect_evt(1, ch);
  endtask

  task automatic match(int unit, int ch);
    int idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].unit == unit && sb[k].ch == ch) idx = k;
    if (idx < 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_pulse u%0d ch%0d: got pulse at cycle %0d, expected none",
               unit, ch, cyc);
    end else begin
      check($sformatf("pulse_cycle_u%0d_ch%0d", unit, ch), cyc, sb[idx].cyc);
      sb.delete(idx);
    end
  endtask

  always @(negedge clk_b) begin
    for (int c = 0; c < 4; c++) if (bus.evt_pulse[c]) match(0, c);
    for (int c = 0; c < 2; c++) if (bus_s.evt_pulse[c]) match(1, c);
  end

  task automatic check_all_zero(string tag);
    check({tag, "_lvl"},   int'(bus.lvl_out),   0);
    check({tag, "_pulse"}, int'(bus.evt_pulse), 0);
    check({tag, "_pend"},  int'(bus.evt_pend),  0);
    check({tag, "_ovf"},   int'(bus.evt_ovf),   0);
    check({tag, "_cnt"},   int'(bus.evt_cnt),   0);
    check({tag, "_s_cnt"}, int'(bus_s.evt_cnt), 0);
    check({tag, "_s_pend"}, int'(bus_s.evt_pend), 0);
  endtask

  initial begin
    // ch2, mode both: {toggle, ack, clr} -> {pend, ovf, cnt}
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};

    bus.async_in    = 4'b1000;
    bus.edge_mode   = 8'b00_10_10_00;
    bus.evt_ack     = '0;
    bus.cnt_clr     = 1'b0;
    bus_s.async_in  = '0;
    bus_s.edge_mode = 4'b00_10;
    bus_s.evt_ack   = '0;
    bus_s.cnt_clr   = 1'b0;

    repeat (3) @(negedge clk_b);
    check_all_zero("reset");

    // ch3 held high through reset: one rise after normal latency
    rst_n_b = 1'b1;
    expect_evt(0, 3);
    repeat (LAT + 3) @(negedge clk_b);
    check("rel_lvl3",  int'(bus.lvl_out[3]),  1);
    check("rel_pend3", int'(bus.evt_pend[3]), 1);
    check("rel_cnt3",  cnt_m(3), 1);

    // ch0 rise, mode 00
    tog(0, 1'b1);
    repeat (LAT + 2) @(negedge clk_b);
    check("rise_pend0", int'(bus.evt_pend[0]), 1);
    check("rise_ovf0",  int'(bus.evt_ovf[0]),  0);
    check("rise_cnt0",  cnt_m(0), 1);

    // ch1, mode both: four toggles without ack
    for (int k = 0; k < 4; k++) begin
      tog(1, 1'b1);
      repeat (8) @(negedge clk_b);
    end
    check("both_cnt1",  cnt_m(1), 4);
    check("both_pend1", int'(bus.evt_pend[1]), 1);
    check("both_ovf1",  int'(bus.evt_ovf[1]),  1);
    bus.evt_ack[1] = 1'b1;
    @(negedge clk_b);
    bus.evt_ack[1] = 1'b0;
    @(negedge clk_b);
    check("ack_pend1", int'(bus.evt_pend[1]), 0);
    check("ack_ovf1",  int'(bus.evt_ovf[1]),  0);
    check("ack_cnt1",  cnt_m(1), 4);

    // ch3 off: prep low, three toggles ending high, then switch to rise
    bus.edge_mode[7:6] = 2'b11;
    @(negedge clk_b);
    tog(3, 1'b0);
    repeat (8) @(negedge clk_b);
    for (int k = 0; k < 3; k++) begin
      tog(3, 1'b0);
      repeat (8) @(negedge clk_b);
    end
    bus.edge_mode[7:6] = 2'b00;
    repeat (12) @(negedge clk_b);
    check("off_cnt3",  cnt_m(3), 1);
    check("off_ovf3",  int'(bus.evt_ovf[3]), 0);
    check("off_lvl3",  int'(bus.lvl_out[3]), 1);

    // ch0: 2-cycle glitch, then 5-cycle pulse
    tog(0, 1'b0);
    repeat (8) @(negedge clk_b);
    bus.async_in[0] = 1'b1;
`ifndef EDGE_SYNC_FILTER_EN
    expect_evt(0, 0);
`endif
    repeat (2) @(negedge clk_b);
    bus.async_in[0] = 1'b0;
    repeat (10) @(negedge clk_b);
    bus.async_in[0] = 1'b1;
    expect_evt(0, 0);
    repeat (5) @(negedge clk_b);
    bus.async_in[0] = 1'b0;
    repeat (12) @(negedge clk_b);
`ifdef EDGE_SYNC_FILTER_EN
    check("glitch_cnt0", cnt_m(0), 2);
`else
    check("glitch_cnt0", cnt_m(0), 3);
`endif

    // vector table on ch2
    foreach (tbl[r]) begin
      if (tbl[r].tog) tog(2, 1'b1);
      repeat (LAT) @(negedge clk_b);
      bus.evt_ack[2] = tbl[r].ack;
      bus.cnt_clr    = tbl[r].clr;
      @(negedge clk_b);
      bus.evt_ack[2] = 1'b0;
      bus.cnt_clr    = 1'b0;
      check($sformatf("tbl%0d_pend", r), int'(bus.evt_pend[2]), int'(tbl[r].pend));
      check($sformatf("tbl%0d_ovf", r),  int'(bus.evt_ovf[2]),  int'(tbl[r].ovf));
      check($sformatf("tbl%0d_cnt", r),  cnt_m(2), tbl[r].cnt);
    end
    check("clr_cnt1", cnt_m(1), 0);
    check("clr_pend1_untouched", int'(bus.evt_pend[1]), 0);
    check("clr_pend3_untouched", int'(bus.evt_pend[3]), 1);

    // 2-bit counter saturation, then clear with simultaneous event
    for (int k = 0; k < 5; k++) begin
      tog_s(0, 1'b1);
      repeat (8) @(negedge clk_b);
    end
    check("sat_cnt",  cnt_s(0), 3);
    check("sat_pend", int'(bus_s.evt_pend[0]), 1);
    check("sat_ovf",  int'(bus_s.evt_ovf[0]),  1);
    check("sat_ch1_cnt", cnt_s(1), 0);
    tog_s(0, 1'b1);
    repeat (LAT) @(negedge clk_b);
    bus_s.cnt_clr = 1'b1;
    @(negedge clk_b);
    bus_s.cnt_clr = 1'b0;
    check("clr_evt_cnt", cnt_s(0), 1);
    repeat (4) @(negedge clk_b);

    // reset with ch1 rise in flight
    bus.edge_mode   = 8'b10_10_10_10;
    bus_s.edge_mode = 4'b10_10;
    @(negedge clk_b);
    tog(1, 1'b0);
    @(negedge clk_b);
    rst_n_b = 1'b0;
    @(negedge clk_b);
    check_all_zero("midrst");
    rst_n_b = 1'b1;
    for (int c = 0; c < 4; c++) if (bus.async_in[c]) expect_evt(0, c);
    for (int c = 0; c < 2; c++) if (bus_s.async_in[c]) expect_evt(1, c);
    repeat (LAT + 6) @(negedge clk_b);
    check("post_rst_cnt1", cnt_m(1), 1);

    foreach (sb[k]) begin
      tests++;
      fails++;
      $display("FAIL missing_pulse u%0d ch%0d: got no pulse, expected one at cycle %0d",
               sb[k].unit, sb[k].ch, sb[k].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
